apb4_requester: RTL and testbench

Parametrised APB4 requester for the UART subsystem. It accepts read and write commands on a valid/ready command port and buffers them in a small FIFO. Each command runs as one APB4 transfer with PSTRB/PPROT, wait-state handling and a cycle timeout. The result returns on a valid/ready response port. It sits between the firmware-side register master and the APB-attached UART, and replaces direct pin-level driving of the APB bus.

---
 rtl/apb4_pkg.sv | 18 +
 rtl/apb4_cmd_fifo.sv | 52 +++++
 rtl/apb4_requester.sv | 156 +++++++++++++++
 tb/tb_apb4_requester.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared types for the APB4 requester: FSM state encoding and the PPROT type.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_state_e;

  typedef logic [2:0] prot_t;

  // Packed width of one command entry, so FIFO storage can be sized from the bus widths.
  function automatic int apb4_cmd_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + (data_w / 8) + 3;
  endfunction

endpackage

// File: rtl/apb4_cmd_fifo.sv
// Command FIFO for the APB4 requester. Pointers carry an extra wrap bit so that
// full and empty are told apart without a separate counter.
module apb4_cmd_fifo
  import apb4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge PCLK) begin
    if (i_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Head is read combinationally so IDLE/RESP can launch SETUP on the next edge.
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/apb4_requester.sv
// APB4 requester: buffers valid/ready commands, runs each as one APB4 transfer
// with wait states and an ACCESS-phase timeout, and returns a valid/ready response.
module apb4_requester
  import apb4_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,  // 8, 16 or 32
  parameter int ADDR_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,   // power of two, >= 2
  parameter int TIMEOUT_CYCLES = 16   // 0 disables the timeout
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int SW       = DATA_WIDTH / 8;
  localparam int CMD_BITS = apb4_cmd_bits(ADDR_WIDTH, DATA_WIDTH);
  localparam bit TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
    prot_t                 prot;
  } apb4_cmd_t;

  apb4_cmd_t   w_cmd_in;
  apb4_cmd_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_timeout;
  apb4_state_e r_state;
  logic [TW-1:0] r_tmo_cnt;
  logic        r_ready_en;

  assign w_cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                      strb: cmd_strb, prot: cmd_prot};

  // r_ready_en keeps cmd_ready low while reset is held.
  assign cmd_ready = r_ready_en && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = !w_empty &&
                     ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_timeout = TMO_EN && (r_tmo_cnt == TW'(TMO_LAST));

  apb4_cmd_fifo #(
    .WIDTH (CMD_BITS),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_tmo_cnt   <= '0;
      r_ready_en  <= 1'b0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      unique case (r_state)
        IDLE: begin
        end
        SETUP: begin
          PENABLE   <= 1'b1;
          r_tmo_cnt <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= RESP;
          end else if (w_timeout) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A pop (from IDLE or a consumed RESP) launches the next transfer and overrides the above.
      if (w_pop) begin
        PADDR   <= w_head.addr;
        PWRITE  <= w_head.write;
        PWDATA  <= w_head.write ? w_head.wdata : '0;
        PSTRB   <= w_head.write ? w_head.strb : '0;
        PPROT   <= w_head.prot;
        PSELx   <= 1'b1;
        PENABLE <= 1'b0;
        r_state <= SETUP;
      end
    end
  end

endmodule

// File: tb/tb_apb4_requester.sv
// Self-checking bench for apb4_requester: scoreboard of expected APB transfers and
// responses, a reactive APB slave model, and directed boundary scenarios.
module tb_apb4_requester;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [2:0]    PPROT;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb4_requester #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PPROT       (PPROT),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;   // ACCESS cycles with PREADY low before it rises
    bit            serr;
    logic [DW-1:0] prdata;
    bit            hang;    // PREADY never rises
  } xfer_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
    bit            tmo;
  } rsp_t;

  xfer_t xq[$];
  rsp_t  rq[$];
  int    hs_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_rsp = 0;
  int    cyc = 0;
  int    acc_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit times_out(input xfer_t x);
    return x.hang || (x.waits >= T);
  endfunction

  function automatic int exp_acc(input xfer_t x);
    return times_out(x) ? T : x.waits + 1;
  endfunction

  function automatic rsp_t model_rsp(input xfer_t x);
    rsp_t r;
    if (times_out(x)) begin
      r.rdata = '0;
      r.err   = 1'b1;
      r.tmo   = 1'b1;
    end else begin
      r.rdata = x.write ? '0 : x.prdata;
      r.err   = x.serr;
      r.tmo   = 1'b0;
    end
    return r;
  endfunction

  function automatic xfer_t mk(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s, input logic [2:0] p, input int waits,
                               input bit serr, input logic [DW-1:0] prd, input bit hang);
    xfer_t x;
    x.write = w;  x.addr = a;  x.wdata = d;  x.strb = s;  x.prot = p;
    x.waits = waits;  x.serr = serr;  x.prdata = prd;  x.hang = hang;
    return x;
  endfunction

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  // Slave model plus APB and response monitors, sampled 1ns after the falling edge.
  initial begin : monitor
    xfer_t x;
    rsp_t  e;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    forever begin
      @(negedge PCLK);
      #1;
      if (PRESET) begin
        xq.delete();
        rq.delete();
        acc_cnt = 0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end else begin
        if (rsp_valid) begin
          check_eq("rsp_expected", rq.size() != 0, 1'b1);
          if (rsp_ready && rq.size() != 0) begin
            e = rq.pop_front();
            $display("rsp #%0d cyc=%0d rdata=%h err=%b tmo=%b", n_rsp, cyc, rsp_rdata, rsp_err, rsp_timeout);
            check_eq("rsp_rdata", rsp_rdata, e.rdata);
            check_eq("rsp_err", rsp_err, e.err);
            check_eq("rsp_timeout", rsp_timeout, e.tmo);
            hs_q.push_back(cyc);
            n_rsp++;
          end
        end
        if (PSELx) begin
          check_eq("apb_expected", xq.size() != 0, 1'b1);
        end
        if (PSELx && xq.size() != 0) begin
          x = xq[0];
          check_eq("paddr", PADDR, x.addr);
          check_eq("pwrite", PWRITE, x.write);
          check_eq("pwdata", PWDATA, x.write ? x.wdata : '0);
          check_eq("pstrb", PSTRB, x.write ? x.strb : '0);
          check_eq("pprot", PPROT, x.prot);
        end
        if (PSELx && PENABLE && xq.size() != 0) begin
          acc_cnt++;
          PREADY  = !x.hang && (acc_cnt > x.waits);
          PRDATA  = x.prdata;
          PSLVERR = PREADY && x.serr;
        end else begin
          if (acc_cnt != 0) begin
            check_eq("access_cycles", acc_cnt, exp_acc(xq[0]));
            void'(xq.pop_front());
            acc_cnt = 0;
          end
          PREADY  = 1'b0;
          PSLVERR = 1'b0;
        end
      end
    end
  end

  task automatic push_cmd(input xfer_t x);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = x.write;
    cmd_addr  = x.addr;
    cmd_wdata = x.wdata;
    cmd_strb  = x.strb;
    cmd_prot  = x.prot;
    while (!cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check_eq("push_accepted", cmd_ready, 1'b1);
    if (cmd_ready) begin
      xq.push_back(x);
      rq.push_back(model_rsp(x));
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((rq.size() != 0 || xq.size() != 0) && n < max_cycles) begin
      @(negedge PCLK);
      n++;
    end
    @(negedge PCLK);
    check_eq("drained", (rq.size() == 0) && (xq.size() == 0), 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b1;
    PRESET    = 1'b0;
    #1 PRESET = 1'b1;
    repeat (3) @(negedge PCLK);

    // Reset state
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_psel_penable_pwrite", {PSELx, PENABLE, PWRITE}, 3'b000);
    check_eq("rst_paddr", PADDR, '0);
    check_eq("rst_pwdata_pstrb_pprot", {PWDATA, PSTRB, PPROT}, '0);
    check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check_eq("rst_rsp_rdata", rsp_rdata, '0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("cmd_ready_after_release", cmd_ready, 1'b1);

    // Single zero-wait write: SETUP, ACCESS, then rsp_valid three edges after the push
    push_cmd(mk(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'd0, 0, 1'b0, 32'h0, 1'b0));
    check_eq("t1_idle_rsp_valid", rsp_valid, 1'b0);
    @(negedge PCLK);
    check_eq("t1_setup", {PSELx, PENABLE}, 2'b10);
    check_eq("t1_setup_pstrb", PSTRB, 4'hF);
    @(negedge PCLK);
    check_eq("t1_access", {PSELx, PENABLE}, 2'b11);
    @(negedge PCLK);
    check_eq("t1_rsp_valid", rsp_valid, 1'b1);
    check_eq("t1_apb_idle", {PSELx, PENABLE}, 2'b00);
    wait_drain(50);

    // Read with three wait states
    push_cmd(mk(1'b0, 32'h04, 32'hFFFF_FFFF, 4'hF, 3'd2, 3, 1'b0, 32'h0000_0055, 1'b0));
    wait_drain(50);

    // Slave error on a write, and on a read with wait states (read data still returned)
    push_cmd(mk(1'b1, 32'h20, 32'h1234_5678, 4'h5, 3'd1, 1, 1'b1, 32'h0, 1'b0));
    wait_drain(50);
    push_cmd(mk(1'b0, 32'h24, 32'h0, 4'h0, 3'd5, 2, 1'b1, 32'hCAFE_0001, 1'b0));
    wait_drain(50);

    // Timeout: PREADY never rises
    push_cmd(mk(1'b0, 32'h30, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1));
    wait_drain(100);

    // PREADY on the final permitted ACCESS cycle wins over the timeout
    push_cmd(mk(1'b0, 32'h34, 32'h0, 4'h0, 3'd7, T - 1, 1'b0, 32'h0BAD_F00D, 1'b0));
    wait_drain(100);

    // Back-pressure: five commands while responses are held off
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(mk(i[0], 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), SW'(i + 3), 3'(i), 0, 1'b0,
                  32'hB0 + 32'(i), 1'b0));
    end
    check_eq("bp_cmd_ready_low", cmd_ready, 1'b0);
    hs_q.delete();
    rsp_ready = 1'b1;
    wait_drain(100);
    check_eq("bp_rsp_count", hs_q.size(), 5);
    for (int i = 1; i < hs_q.size(); i++) begin
      check_eq("bp_gap", hs_q[i] - hs_q[i-1], 3);
    end

    // Reset asserted mid-ACCESS
    push_cmd(mk(1'b1, 32'h40, 32'h7777_0000, 4'hF, 3'd3, 0, 1'b0, 32'h0, 1'b1));
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check_eq("rst_mid_reached_access", PENABLE, 1'b1);
    repeat (2) @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    check_eq("rst_mid_apb_ctrl", {PSELx, PENABLE, PWRITE}, 3'b000);
    check_eq("rst_mid_apb_data", {PADDR, PWDATA, PSTRB, PPROT}, '0);
    check_eq("rst_mid_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check_eq("rst_mid_cmd_ready", cmd_ready, 1'b0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("rst_mid_cmd_ready_after", cmd_ready, 1'b1);
    repeat (25) @(negedge PCLK);
    check_eq("rst_mid_no_rsp", rsp_valid, 1'b0);
    check_eq("rst_mid_no_psel", PSELx, 1'b0);

    // Recovery after reset
    push_cmd(mk(1'b1, 32'h44, 32'h0F0F_0F0F, 4'h3, 3'd4, 0, 1'b0, 32'h0, 1'b0));
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
